// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding and default register-index width,
// used by the controller and by the pipeline registers it drives.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_REG_INDEX_BIT_WIDTH = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] count_r;

  // count up on inc until all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != {CNT_BITS{1'b1}})) begin
      count_r <= count_r + CNT_BITS'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory freeze, mispredict flush and load-use bubble insertion,
// with a sticky memory-timeout flag and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BIT_WIDTH,
  parameter int MAX_WAIT            = 15,
  parameter int CNT_BITS            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs2,
  input  logic                           DEC_useRs1,
  input  logic                           DEC_useRs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
  input  logic                           EX_wrReg,
  input  logic                           EX_isLoad,
  input  logic                           EX_mispredict,
  input  logic                           MEM_busy,
  output logic                           PC_wrt_en,
  output logic                           IF_wrt_en,
  output logic                           DEC_wrt_en,
  output logic                           IF_flush,
  output logic                           DEC_flush,
  output logic                           mem_timeout,
  output logic [CNT_BITS-1:0]            stall_cnt,
  output logic [CNT_BITS-1:0]            flush_cnt
);

  localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);

  ctrl_state_e          state_r;
  ctrl_state_e          state_next_s;
  logic [WAIT_BITS-1:0] wait_cnt_r;
  logic                 mem_timeout_r;
  logic                 hazard_s;
  logic                 hazard_masked_s;
  logic                 pc_en_s, if_en_s, dec_en_s;
  logic                 if_flush_s, dec_flush_s;
  logic                 flush_inc_s;
  logic                 stall_inc_s;

  assign hazard_s = EX_isLoad & EX_wrReg & (EX_rd != '0) &
                    ((DEC_useRs1 & (DEC_rs1 == EX_rd)) | (DEC_useRs2 & (DEC_rs2 == EX_rd)));

  // the cycle after a bubble or flush the decode slot is already cleared, so ignore hazards
  assign hazard_masked_s = (state_r == LOAD_STALL) || (state_r == FLUSH);

  // control outputs and next state, prioritised freeze > flush > bubble > run
  always_comb begin
    pc_en_s      = 1'b1;
    if_en_s      = 1'b1;
    dec_en_s     = 1'b1;
    if_flush_s   = 1'b0;
    dec_flush_s  = 1'b0;
    flush_inc_s  = 1'b0;
    state_next_s = RUN;
    if (reset) begin
      pc_en_s     = 1'b0;
      if_en_s     = 1'b0;
      dec_en_s    = 1'b0;
      if_flush_s  = 1'b1;
      dec_flush_s = 1'b1;
    end else if (MEM_busy) begin
      // EX is frozen, so a pending mispredict stays visible until the freeze ends
      pc_en_s      = 1'b0;
      if_en_s      = 1'b0;
      dec_en_s     = 1'b0;
      state_next_s = MEM_WAIT;
    end else if (EX_mispredict) begin
      if_flush_s   = 1'b1;
      dec_flush_s  = 1'b1;
      flush_inc_s  = 1'b1;
      state_next_s = FLUSH;
    end else if (hazard_s && !hazard_masked_s) begin
      pc_en_s      = 1'b0;
      if_en_s      = 1'b0;
      dec_flush_s  = 1'b1;
      state_next_s = LOAD_STALL;
    end else begin
      state_next_s = RUN;
    end
  end

  // state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (MEM_busy) begin
        if (wait_cnt_r != WAIT_BITS'(MAX_WAIT)) begin
          wait_cnt_r <= wait_cnt_r + WAIT_BITS'(1);
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
        if (wait_cnt_r >= WAIT_BITS'(MAX_WAIT - 1)) begin
          mem_timeout_r <= 1'b1;
        end else begin
          mem_timeout_r <= mem_timeout_r;
        end
      end else begin
        wait_cnt_r    <= '0;
        mem_timeout_r <= mem_timeout_r;
      end
    end
  end

  assign stall_inc_s = ~pc_en_s & ~reset;

  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

  assign PC_wrt_en   = pc_en_s;
  assign IF_wrt_en   = if_en_s;
  assign DEC_wrt_en  = dec_en_s;
  assign IF_flush    = if_flush_s;
  assign DEC_flush   = dec_flush_s;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic,
// compared against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int RW       = 4;
  localparam int MAX_WAIT = 15;
  localparam int CNT_BITS = 8;
  localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

  logic          clk;
  logic          reset;
  logic [RW-1:0] DEC_rs1, DEC_rs2, EX_rd;
  logic          DEC_useRs1, DEC_useRs2, EX_wrReg, EX_isLoad, EX_mispredict, MEM_busy;
  logic          PC_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush, mem_timeout;
  logic [CNT_BITS-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_after_bubble = 1'b0;
  int m_wait         = 0;
  bit m_timeout      = 1'b0;
  int m_stall        = 0;
  int m_flush        = 0;

  pipeline_ctrl #(
    .REG_INDEX_BIT_WIDTH(RW),
    .MAX_WAIT           (MAX_WAIT),
    .CNT_BITS           (CNT_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .DEC_rs1      (DEC_rs1),
    .DEC_rs2      (DEC_rs2),
    .DEC_useRs1   (DEC_useRs1),
    .DEC_useRs2   (DEC_useRs2),
    .EX_rd        (EX_rd),
    .EX_wrReg     (EX_wrReg),
    .EX_isLoad    (EX_isLoad),
    .EX_mispredict(EX_mispredict),
    .MEM_busy     (MEM_busy),
    .PC_wrt_en    (PC_wrt_en),
    .IF_wrt_en    (IF_wrt_en),
    .DEC_wrt_en   (DEC_wrt_en),
    .IF_flush     (IF_flush),
    .DEC_flush    (DEC_flush),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit busy, input bit mis, input bit ld, input bit wr,
                       input int rd, input int rs1, input bit u1, input int rs2, input bit u2);
    reset         = rst;
    MEM_busy      = busy;
    EX_mispredict = mis;
    EX_isLoad     = ld;
    EX_wrReg      = wr;
    EX_rd         = RW'(rd);
    DEC_rs1       = RW'(rs1);
    DEC_useRs1    = u1;
    DEC_rs2       = RW'(rs2);
    DEC_useRs2    = u2;
  endtask

  // one clock: check control outputs mid-cycle, advance the model at the edge, check counters after
  task automatic run_cycle();
    bit haz;
    int exp_ctl;
    int pc_en;
    #1;
    haz = EX_isLoad && EX_wrReg && (EX_rd != 0) &&
          ((DEC_useRs1 && DEC_rs1 == EX_rd) || (DEC_useRs2 && DEC_rs2 == EX_rd));
    if (reset)                          exp_ctl = 5'b000_11;
    else if (MEM_busy)                  exp_ctl = 5'b000_00;
    else if (EX_mispredict)             exp_ctl = 5'b111_11;
    else if (haz && !m_after_bubble)    exp_ctl = 5'b001_01;
    else                                exp_ctl = 5'b111_00;
    check_eq("ctl{pc,if,dec,iff,decf}",
             int'({PC_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush}), exp_ctl);
    pc_en = (exp_ctl >> 4) & 1;
    @(posedge clk);
    if (reset) begin
      m_after_bubble = 1'b0;
      m_wait = 0;
      m_timeout = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_after_bubble = !MEM_busy && (EX_mispredict || (haz && !m_after_bubble));
      if (MEM_busy) begin
        if (m_wait + 1 >= MAX_WAIT) m_timeout = 1'b1;
        m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      end else begin
        m_wait = 0;
      end
      if (pc_en == 0 && m_stall < CNT_MAX) m_stall++;
      if (!MEM_busy && EX_mispredict && m_flush < CNT_MAX) m_flush++;
    end
    #1;
    check_eq("stall_cnt", int'(stall_cnt), m_stall);
    check_eq("flush_cnt", int'(flush_cnt), m_flush);
    check_eq("mem_timeout", int'(mem_timeout), int'(m_timeout));
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    run_cycle();
  endtask

  initial begin
    bit busy;
    int busy_left;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    check_eq("reset_stall_cnt", int'(stall_cnt), 0);

    // load-use on rs1 -> one bubble, then normal
    drive(0, 0, 0, 1, 1, 3, 3, 1, 0, 0);
    run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check_eq("loaduse_stall_cnt", int'(stall_cnt), 1);

    // rd = 0 and unused source -> no stall
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    run_cycle();
    drive(0, 0, 0, 1, 1, 3, 3, 0, 5, 1);
    run_cycle();
    check_eq("nohaz_stall_cnt", int'(stall_cnt), 0);

    // mispredict pulse, hazard the following cycle is masked
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check_eq("mispredict_flush_cnt", int'(flush_cnt), 1);
    drive(0, 0, 0, 1, 1, 2, 0, 0, 2, 1);
    run_cycle();
    check_eq("masked_hazard_stall", int'(stall_cnt), 0);

    // 20-cycle freeze with pending mispredict, timeout at count 15
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      run_cycle();
      if (i == 14) check_eq("timeout_before_15", int'(mem_timeout), 0);
      if (i == 15) check_eq("timeout_at_15", int'(mem_timeout), 1);
    end
    check_eq("freeze_stall_cnt", int'(stall_cnt), 20);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check_eq("deferred_flush_cnt", int'(flush_cnt), 1);
    check_eq("timeout_sticky", int'(mem_timeout), 1);

    // reset in the middle of a memory wait
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check_eq("rst_wait_stall", int'(stall_cnt), 0);
    check_eq("rst_wait_timeout", int'(mem_timeout), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle();

    // saturation of stall_cnt
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle();
    end
    check_eq("stall_cnt_saturated", int'(stall_cnt), CNT_MAX);

    // randomized traffic
    do_reset();
    busy_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (busy_left > 0) begin
        busy_left--;
        busy = 1'b1;
      end else if ($urandom_range(0, 9) == 0) begin
        busy_left = $urandom_range(0, 18);
        busy = 1'b1;
      end else begin
        busy = 1'b0;
      end
      drive(($urandom_range(0, 79) == 0), busy, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
